// File: rtl/serial_bit_source.sv
// serial_bit_source
//   Parallel-to-serial bit source feeding the X input of a sequence detector.
//   A word is accepted on a LOAD/READY handshake and shifted out one bit per
//   clock. A new word may be accepted in the last-bit cycle, so consecutive
//   words reach the detector with no gap bits.
//   Optional feature: define SERIAL_PARITY_EN to append an even-parity bit
//   (^din, captured at accept) after the data bits.
module serial_bit_source #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             x_out,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int              CW        = $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(N - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_s;
  logic             x_s;
  logic             busy_s;
  logic             done_s;
  logic             last_s;
  logic             accept_s;
`ifdef SERIAL_PARITY_EN
  logic             par_r;
  logic             par_s;
  localparam logic [CW-1:0] CNT_DATA_LAST = CW'(WIDTH - 1);

  // Even parity over a data word: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  // The bit that goes out first from a word in the shift register.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Drop the head bit and move the next one into the head position.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // The last bit is on x_out; a new word may be taken on the coming edge.
  assign last_s   = (state_r == SHIFT) && (cnt_r == CNT_LAST);
  assign ready    = (state_r == IDLE) || last_s;
  assign accept_s = load && ready;

  // Next-state and next-output decode for the shifter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shreg_s = shreg_r;
    x_s     = x_out;
    busy_s  = busy;
    done_s  = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_s   = par_r;
`endif
    if (accept_s) begin
      // Fresh word, either from idle or back-to-back after a last bit.
      state_s = SHIFT;
      cnt_s   = CNT_ZERO;
      x_s     = head_bit(din);
      shreg_s = shift_word(din);
      busy_s  = 1'b1;
      done_s  = last_s;
`ifdef SERIAL_PARITY_EN
      par_s   = even_parity(din);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          x_s    = IDLE_LEVEL;
          busy_s = 1'b0;
        end
        SHIFT: begin
          if (last_s) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            x_s     = IDLE_LEVEL;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
`ifdef SERIAL_PARITY_EN
            if (cnt_r == CNT_DATA_LAST) begin
              x_s = par_r;
            end else begin
              x_s     = head_bit(shreg_r);
              shreg_s = shift_word(shreg_r);
            end
`else
            x_s     = head_bit(shreg_r);
            shreg_s = shift_word(shreg_r);
`endif
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          x_s     = IDLE_LEVEL;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State, counter, shift register and registered outputs; reset aborts any word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      shreg_r <= {WIDTH{1'b0}};
      x_out   <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shreg_r <= shreg_s;
      x_out   <= x_s;
      busy    <= busy_s;
      done    <= done_s;
`ifdef SERIAL_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source
//   Scoreboard bench for serial_bit_source (WIDTH=8, MSB first, idle 0).
//   Every accepted word pushes its expected bit sequence; each cycle the
//   monitor pops one expected bit while a word should be in flight and checks
//   x_out, busy, done and ready. Builds with or without SERIAL_PARITY_EN.
module tb_serial_bit_source;

  localparam int WIDTH = 8;
`ifdef SERIAL_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             x_out;
  logic             busy;
  logic             done;

  typedef struct packed {
    logic x;
    logic last;
  } sb_t;

  sb_t sb_q[$];
  int  total;
  int  bad;
  int  cyc;
  int  n_done;
  int  prev_done_cyc;
  int  last_done_cyc;
  logic exp_done_next;

  serial_bit_source #(
    .WIDTH      (WIDTH),
    .MSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .load  (load),
    .ready (ready),
    .x_out (x_out),
    .busy  (busy),
    .done  (done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected bits of one word, MSB first, optional parity bit at the end.
  task automatic push_word(input logic [WIDTH-1:0] w);
    sb_t e;
    for (int i = 0; i < WIDTH; i++) begin
      e.x    = w[WIDTH-1-i];
      e.last = (i == N - 1);
      sb_q.push_back(e);
    end
`ifdef SERIAL_PARITY_EN
    e.x    = ^w;
    e.last = 1'b1;
    sb_q.push_back(e);
`endif
  endtask

  // One clock: sample #1 after the rising edge and compare against the scoreboard.
  task automatic tick();
    sb_t e;
    logic exp_busy;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    exp_busy = (sb_q.size() != 0);
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    check("done", {31'd0, done}, {31'd0, exp_done_next});
    if (done === 1'b1) begin
      n_done        = n_done + 1;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    if (exp_busy) begin
      e = sb_q.pop_front();
      check("x_bit", {31'd0, x_out}, {31'd0, e.x});
      exp_done_next = e.last;
    end else begin
      check("x_idle", {31'd0, x_out}, 32'd0);
      exp_done_next = 1'b0;
    end
    check("ready", {31'd0, ready}, {31'd0, (sb_q.size() == 0)});
  endtask

  // Present a word with LOAD for one edge; caller guarantees READY is expected high.
  task automatic send(input logic [WIDTH-1:0] w);
    din  = w;
    load = 1'b1;
    push_word(w);
    tick();
    load = 1'b0;
  endtask

  initial begin
    int done_before;
    total         = 0;
    bad           = 0;
    cyc           = 0;
    n_done        = 0;
    prev_done_cyc = 0;
    last_done_cyc = 0;
    exp_done_next = 1'b0;
    rst           = 1'b1;
    load          = 1'b0;
    din           = {WIDTH{1'b0}};

    // 1: reset held with the clock running, then released
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 2: single word 8'hA5
    done_before = n_done;
    send(8'hA5);
    repeat (N - 1) tick();
    repeat (2) tick();
    check("single_done_cnt", n_done - done_before, 1);

    // 3: back-to-back 8'h01 then 8'h80 loaded in the last-bit cycle
    done_before = n_done;
    send(8'h01);
    repeat (N - 1) tick();
    check("b2b_ready_last", {31'd0, ready}, 32'd1);
    send(8'h80);
    repeat (N - 1) tick();
    repeat (2) tick();
    check("b2b_done_cnt", n_done - done_before, 2);
    check("b2b_done_gap", last_done_cyc - prev_done_cyc, N);

    // 4: LOAD of 8'hFF while bit 3 of 8'h00 is on the line is ignored
    send(8'h00);
    repeat (3) tick();
    check("ign_ready", {31'd0, ready}, 32'd0);
    din  = 8'hFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    din  = 8'h00;
    repeat (N - 1 - 4) tick();
    repeat (2) tick();

    // 5: reset in the middle of 8'hFF, then 8'h0F goes out cleanly
    done_before = n_done;
    send(8'hFF);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("rst_x", {31'd0, x_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    sb_q.delete();
    exp_done_next = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_no_done", n_done - done_before, 0);
    send(8'h0F);
    repeat (N - 1) tick();
    repeat (2) tick();
    check("after_rst_done", n_done - done_before, 1);

`ifdef SERIAL_PARITY_EN
    // 6: parity word 8'h07 -> 0,0,0,0,0,1,1,1 then parity 1
    done_before = n_done;
    send(8'h07);
    repeat (N - 1) tick();
    repeat (2) tick();
    check("par_done_cnt", n_done - done_before, 1);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
